array_op_scheduler: RTL and testbench

//   In-order scheduler between the decode-stage array issue port and the shared vector array unit.

---
 rtl/array_pkg.sv | 40 ++++
 rtl/array_op_scheduler_if.sv | 47 ++++
 rtl/array_sched_fifo.sv | 45 ++++
 rtl/array_op_scheduler.sv | 109 ++++++++++
 tb/tb_array_op_scheduler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/array_pkg.sv
// Opcode constants, operand-usage decode and the queued-op header shared by
// the array op scheduler, its queue and its bus interface.
package array_pkg;

  localparam int VREG_IDX_W = 5;
  localparam int OPC_W      = 7;

  localparam logic [OPC_W-1:0] ARRAY_ADD   = 7'b1111000;
  localparam logic [OPC_W-1:0] ARRAY_MULT  = 7'b1111001;
  localparam logic [OPC_W-1:0] ARRAY_LOAD  = 7'b1111010;
  localparam logic [OPC_W-1:0] ARRAY_STORE = 7'b1111011;
  localparam logic [OPC_W-1:0] ARRAY_RELU  = 7'b1111100;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [VREG_IDX_W-1:0] rd;
    logic [VREG_IDX_W-1:0] rs1;
    logic [VREG_IDX_W-1:0] rs2;
  } opHdr_t;

  function automatic logic is_array_op(input logic [OPC_W-1:0] opc);
    return (opc == ARRAY_ADD) || (opc == ARRAY_MULT) || (opc == ARRAY_LOAD) ||
           (opc == ARRAY_STORE) || (opc == ARRAY_RELU);
  endfunction

  function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
    return (opc == ARRAY_ADD) || (opc == ARRAY_MULT) ||
           (opc == ARRAY_RELU) || (opc == ARRAY_STORE);
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
    return (opc == ARRAY_ADD) || (opc == ARRAY_MULT);
  endfunction

  function automatic logic writes_rd(input logic [OPC_W-1:0] opc);
    return (opc == ARRAY_ADD) || (opc == ARRAY_MULT) ||
           (opc == ARRAY_LOAD) || (opc == ARRAY_RELU);
  endfunction

endpackage

// File: rtl/array_op_scheduler_if.sv
// Issue, dispatch and retire signals between decode, the scheduler and the
// vector array unit. The scheduler takes the slave side.
interface array_op_scheduler_if #(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 4
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic                             issue_valid;
  logic [array_pkg::OPC_W-1:0]      issue_opcode;
  logic [array_pkg::VREG_IDX_W-1:0] issue_rd;
  logic [array_pkg::VREG_IDX_W-1:0] issue_rs1;
  logic [array_pkg::VREG_IDX_W-1:0] issue_rs2;
  logic [WIDTH-1:0]                 issue_addr;
  logic [WIDTH-1:0]                 issue_stride;
  logic                             issue_busy;

  logic                             disp_valid;
  logic                             disp_ready;
  logic [array_pkg::OPC_W-1:0]      disp_opcode;
  logic [array_pkg::VREG_IDX_W-1:0] disp_rd;
  logic [array_pkg::VREG_IDX_W-1:0] disp_rs1;
  logic [array_pkg::VREG_IDX_W-1:0] disp_rs2;
  logic [WIDTH-1:0]                 disp_addr;
  logic [WIDTH-1:0]                 disp_stride;

  logic                             done_valid;
  logic [array_pkg::VREG_IDX_W-1:0] done_rd;

  logic                             sched_idle;
  logic [CNT_W-1:0]                 q_count;

  modport master (
    output issue_valid, issue_opcode, issue_rd, issue_rs1, issue_rs2,
           issue_addr, issue_stride, disp_ready, done_valid, done_rd,
    input  issue_busy, disp_valid, disp_opcode, disp_rd, disp_rs1, disp_rs2,
           disp_addr, disp_stride, sched_idle, q_count
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_rd, issue_rs1, issue_rs2,
           issue_addr, issue_stride, disp_ready, done_valid, done_rd,
    output issue_busy, disp_valid, disp_opcode, disp_rd, disp_rs1, disp_rs2,
           disp_addr, disp_stride, sched_idle, q_count
  );

endinterface

// File: rtl/array_sched_fifo.sv
// Circular op queue for the array scheduler. The head entry is presented
// combinationally; the caller never pushes when full or pops when empty.
module array_sched_fifo #(
  parameter int WIDTH  = 8,
  parameter int QDEPTH = 4,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // Pointers are exactly log2(QDEPTH) bits, so they wrap on their own.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/array_op_scheduler.sv
// In-order array op scheduler: queues decoded array ops, tracks pending vreg
// writes in a scoreboard and dispatches the head op once it is hazard-free.
module array_op_scheduler
  import array_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 4,
  parameter int VREGS  = 32
) (
  input logic                  CLK,
  input logic                  RST,
  array_op_scheduler_if.slave  bus
);

  localparam int CNT_W   = $clog2(QDEPTH) + 1;
  localparam int ENTRY_W = $bits(opHdr_t) + 2 * WIDTH;

  opHdr_t             issueHdr;
  opHdr_t             headHdr;
  logic [WIDTH-1:0]   headAddr;
  logic [WIDTH-1:0]   headStride;
  logic [ENTRY_W-1:0] headEntry;
  logic [CNT_W-1:0]   count;

  logic               busy;
  logic               push;
  logic               headEligible;
  logic               load;

  logic [VREGS-1:0]   sb;
  logic [VREGS-1:0]   sbNext;

  logic               dispValid;
  opHdr_t             dispHdr;
  logic [WIDTH-1:0]   dispAddr;
  logic [WIDTH-1:0]   dispStride;

  assign issueHdr = '{opcode: bus.issue_opcode, rd: bus.issue_rd,
                      rs1: bus.issue_rs1, rs2: bus.issue_rs2};

  // Busy comes from the registered count only; a same-cycle pop earns no credit.
  assign busy = (count == CNT_W'(QDEPTH));
  assign push = bus.issue_valid && !busy && is_array_op(bus.issue_opcode);

  array_sched_fifo #(
    .WIDTH  (ENTRY_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .pushData ({issueHdr, bus.issue_addr, bus.issue_stride}),
    .pop      (load),
    .headData (headEntry),
    .count    (count)
  );

  assign {headHdr, headAddr, headStride} = headEntry;

  // RAW on each used source, WAW on the destination, against registered sb.
  always_comb begin
    headEligible = (count != '0);
    if (uses_rs1(headHdr.opcode) && sb[headHdr.rs1])  headEligible = 1'b0;
    if (uses_rs2(headHdr.opcode) && sb[headHdr.rs2])  headEligible = 1'b0;
    if (writes_rd(headHdr.opcode) && sb[headHdr.rd])  headEligible = 1'b0;
  end

  assign load = headEligible && (!dispValid || bus.disp_ready);

  // Clear first so a same-cycle set of the same vreg wins.
  always_comb begin
    sbNext = sb;
    if (bus.done_valid) sbNext[bus.done_rd] = 1'b0;
    if (load && writes_rd(headHdr.opcode)) sbNext[headHdr.rd] = 1'b1;
  end

  // Dispatch output register stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sb         <= '0;
      dispValid  <= 1'b0;
      dispHdr    <= '0;
      dispAddr   <= '0;
      dispStride <= '0;
    end else begin
      sb <= sbNext;
      if (load) begin
        dispValid  <= 1'b1;
        dispHdr    <= headHdr;
        dispAddr   <= headAddr;
        dispStride <= headStride;
      end else if (dispValid && bus.disp_ready) begin
        dispValid  <= 1'b0;
      end
    end
  end

  assign bus.issue_busy  = busy;
  assign bus.disp_valid  = dispValid;
  assign bus.disp_opcode = dispHdr.opcode;
  assign bus.disp_rd     = dispHdr.rd;
  assign bus.disp_rs1    = dispHdr.rs1;
  assign bus.disp_rs2    = dispHdr.rs2;
  assign bus.disp_addr   = dispAddr;
  assign bus.disp_stride = dispStride;
  assign bus.q_count     = count;
  assign bus.sched_idle  = (count == '0) && !dispValid && (sb == '0);

endmodule

// File: tb/tb_array_op_scheduler.sv
// Directed bench for array_op_scheduler: dispatch latency, RAW/WAW holds,
// queue-full back-pressure, output stall and mid-operation reset.
module tb_array_op_scheduler;
  import array_pkg::*;

  logic CLK;
  logic RST;
  int   passCnt;
  int   totalCnt;

  array_op_scheduler_if #(.WIDTH(32), .QDEPTH(4)) ifc ();

  array_op_scheduler #(.WIDTH(32), .QDEPTH(4), .VREGS(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] a, input logic [31:0] s);
    ifc.issue_valid  = v;
    ifc.issue_opcode = op;
    ifc.issue_rd     = rd;
    ifc.issue_rs1    = r1;
    ifc.issue_rs2    = r2;
    ifc.issue_addr   = a;
    ifc.issue_stride = s;
  endtask

  task automatic doReset();
    RST = 1'b1;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    ifc.disp_ready = 1'b0;
    ifc.done_valid = 1'b0;
    ifc.done_rd    = 5'd0;
    step(1);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL reset_disp_valid got=%0b want=0", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.issue_busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", ifc.issue_busy); else passCnt++;
    totalCnt++; if (ifc.sched_idle !== 1'b1) $display("FAIL reset_idle got=%0b want=1", ifc.sched_idle); else passCnt++;
    totalCnt++; if (ifc.q_count !== 3'd0) $display("FAIL reset_qcount got=%0d want=0", ifc.q_count); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd0) $display("FAIL reset_disp_rd got=%0d want=0", ifc.disp_rd); else passCnt++;
  endtask

  task automatic test_basic_dispatch();
    doReset();
    ifc.disp_ready = 1'b1;
    drive(1'b1, ARRAY_ADD, 5'd3, 5'd1, 5'd2, 32'h100, 32'h8);
    step(1);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    totalCnt++; if (ifc.q_count !== 3'd1) $display("FAIL basic_enq_count got=%0d want=1", ifc.q_count); else passCnt++;
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL basic_no_bypass got=%0b want=0", ifc.disp_valid); else passCnt++;
    step(1);
    totalCnt++; if (ifc.disp_valid !== 1'b1) $display("FAIL basic_disp_valid got=%0b want=1", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd3) $display("FAIL basic_disp_rd got=%0d want=3", ifc.disp_rd); else passCnt++;
    totalCnt++; if (ifc.disp_opcode !== ARRAY_ADD) $display("FAIL basic_disp_opcode got=%b want=%b", ifc.disp_opcode, ARRAY_ADD); else passCnt++;
    totalCnt++; if (ifc.disp_addr !== 32'h100) $display("FAIL basic_disp_addr got=%h want=100", ifc.disp_addr); else passCnt++;
    totalCnt++; if (dut.sb[3] !== 1'b1) $display("FAIL basic_sb3 got=%0b want=1", dut.sb[3]); else passCnt++;
    totalCnt++; if (ifc.sched_idle !== 1'b0) $display("FAIL basic_idle got=%0b want=0", ifc.sched_idle); else passCnt++;
    step(1);
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL basic_disp_drop got=%0b want=0", ifc.disp_valid); else passCnt++;
  endtask

  task automatic test_raw_hazard();
    doReset();
    ifc.disp_ready = 1'b1;
    drive(1'b1, ARRAY_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0);
    step(1);
    drive(1'b1, ARRAY_RELU, 5'd4, 5'd3, 5'd0, 32'h0, 32'h0);
    step(1);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    step(2);
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL raw_held_valid got=%0b want=0", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.q_count !== 3'd1) $display("FAIL raw_held_count got=%0d want=1", ifc.q_count); else passCnt++;
    ifc.done_valid = 1'b1;
    ifc.done_rd    = 5'd3;
    step(1);
    ifc.done_valid = 1'b0;
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL raw_done_same_cycle got=%0b want=0", ifc.disp_valid); else passCnt++;
    step(1);
    totalCnt++; if (ifc.disp_valid !== 1'b1) $display("FAIL raw_release_valid got=%0b want=1", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.disp_opcode !== ARRAY_RELU) $display("FAIL raw_release_opcode got=%b want=%b", ifc.disp_opcode, ARRAY_RELU); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd4) $display("FAIL raw_release_rd got=%0d want=4", ifc.disp_rd); else passCnt++;
  endtask

  task automatic test_queue_full();
    doReset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ARRAY_LOAD, 5'(10 + i), 5'd0, 5'd0, 32'h1000 + 32'(i * 8), 32'h8);
      step(1);
    end
    drive(1'b1, ARRAY_LOAD, 5'd15, 5'd0, 5'd0, 32'h1028, 32'h8);
    totalCnt++; if (ifc.q_count !== 3'd4) $display("FAIL full_count got=%0d want=4", ifc.q_count); else passCnt++;
    totalCnt++; if (ifc.issue_busy !== 1'b1) $display("FAIL full_busy got=%0b want=1", ifc.issue_busy); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd10) $display("FAIL full_disp_rd got=%0d want=10", ifc.disp_rd); else passCnt++;
    step(2);
    totalCnt++; if (ifc.q_count !== 3'd4) $display("FAIL full_hold_count got=%0d want=4", ifc.q_count); else passCnt++;
    ifc.disp_ready = 1'b1;
    step(1);
    totalCnt++; if (ifc.issue_busy !== 1'b0) $display("FAIL full_busy_drop got=%0b want=0", ifc.issue_busy); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd11) $display("FAIL full_order_11 got=%0d want=11", ifc.disp_rd); else passCnt++;
    step(1);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    totalCnt++; if (ifc.q_count !== 3'd3) $display("FAIL full_pushpop_count got=%0d want=3", ifc.q_count); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd12) $display("FAIL full_order_12 got=%0d want=12", ifc.disp_rd); else passCnt++;
    for (int r = 13; r <= 15; r++) begin
      step(1);
      totalCnt++; if (ifc.disp_rd !== 5'(r)) $display("FAIL full_order got=%0d want=%0d", ifc.disp_rd, r); else passCnt++;
    end
    totalCnt++; if (ifc.disp_addr !== 32'h1028) $display("FAIL full_last_addr got=%h want=1028", ifc.disp_addr); else passCnt++;
    step(1);
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL full_drain_valid got=%0b want=0", ifc.disp_valid); else passCnt++;
  endtask

  task automatic test_waw_hazard();
    doReset();
    ifc.disp_ready = 1'b1;
    drive(1'b1, ARRAY_LOAD, 5'd5, 5'd0, 5'd0, 32'h100, 32'h8);
    step(1);
    drive(1'b1, ARRAY_LOAD, 5'd5, 5'd0, 5'd0, 32'h200, 32'h8);
    step(1);
    drive(1'b1, ARRAY_STORE, 5'd0, 5'd5, 5'd0, 32'h300, 32'h8);
    step(1);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    step(1);
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL waw_held_valid got=%0b want=0", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.q_count !== 3'd2) $display("FAIL waw_held_count got=%0d want=2", ifc.q_count); else passCnt++;
    ifc.done_valid = 1'b1;
    ifc.done_rd    = 5'd5;
    step(1);
    ifc.done_valid = 1'b0;
    step(1);
    totalCnt++; if (ifc.disp_valid !== 1'b1) $display("FAIL waw_release_valid got=%0b want=1", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.disp_addr !== 32'h200) $display("FAIL waw_release_addr got=%h want=200", ifc.disp_addr); else passCnt++;
    step(2);
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL waw_store_held got=%0b want=0", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.q_count !== 3'd1) $display("FAIL waw_store_count got=%0d want=1", ifc.q_count); else passCnt++;
    ifc.done_valid = 1'b1;
    step(1);
    ifc.done_valid = 1'b0;
    step(1);
    totalCnt++; if (ifc.disp_opcode !== ARRAY_STORE) $display("FAIL waw_store_opcode got=%b want=%b", ifc.disp_opcode, ARRAY_STORE); else passCnt++;
    totalCnt++; if (ifc.disp_rs1 !== 5'd5) $display("FAIL waw_store_rs1 got=%0d want=5", ifc.disp_rs1); else passCnt++;
    step(1);
    totalCnt++; if (ifc.sched_idle !== 1'b1) $display("FAIL waw_final_idle got=%0b want=1", ifc.sched_idle); else passCnt++;
  endtask

  task automatic test_output_stall();
    doReset();
    drive(1'b1, ARRAY_MULT, 5'd7, 5'd8, 5'd9, 32'hDEAD0000, 32'h40);
    step(1);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    step(4);
    totalCnt++; if (ifc.disp_valid !== 1'b1) $display("FAIL stall_valid got=%0b want=1", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.disp_rs2 !== 5'd9) $display("FAIL stall_rs2 got=%0d want=9", ifc.disp_rs2); else passCnt++;
    totalCnt++; if (ifc.disp_addr !== 32'hDEAD0000) $display("FAIL stall_addr got=%h want=dead0000", ifc.disp_addr); else passCnt++;
    totalCnt++; if (ifc.disp_stride !== 32'h40) $display("FAIL stall_stride got=%h want=40", ifc.disp_stride); else passCnt++;
    ifc.done_valid = 1'b1;
    ifc.done_rd    = 5'd0;
    step(1);
    ifc.done_valid = 1'b0;
    totalCnt++; if (dut.sb !== 32'h0000_0080) $display("FAIL stall_sb_nop got=%h want=00000080", dut.sb); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd7) $display("FAIL stall_rd_after_done got=%0d want=7", ifc.disp_rd); else passCnt++;
    drive(1'b1, 7'b1111101, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0);
    step(1);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    totalCnt++; if (ifc.q_count !== 3'd0) $display("FAIL illegal_dropped got=%0d want=0", ifc.q_count); else passCnt++;
  endtask

  task automatic test_reset_mid();
    doReset();
    drive(1'b1, ARRAY_ADD, 5'd3, 5'd1, 5'd2, 32'h40, 32'h8);
    step(1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ARRAY_LOAD, 5'(20 + i), 5'd0, 5'd0, 32'h500, 32'h8);
      step(1);
    end
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    totalCnt++; if (ifc.q_count !== 3'd3) $display("FAIL mid_pre_count got=%0d want=3", ifc.q_count); else passCnt++;
    totalCnt++; if (ifc.disp_valid !== 1'b1) $display("FAIL mid_pre_valid got=%0b want=1", ifc.disp_valid); else passCnt++;
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    totalCnt++; if (ifc.disp_valid !== 1'b0) $display("FAIL mid_rst_valid got=%0b want=0", ifc.disp_valid); else passCnt++;
    totalCnt++; if (ifc.disp_rd !== 5'd0) $display("FAIL mid_rst_rd got=%0d want=0", ifc.disp_rd); else passCnt++;
    totalCnt++; if (ifc.disp_addr !== 32'h0) $display("FAIL mid_rst_addr got=%h want=0", ifc.disp_addr); else passCnt++;
    totalCnt++; if (ifc.q_count !== 3'd0) $display("FAIL mid_rst_count got=%0d want=0", ifc.q_count); else passCnt++;
    totalCnt++; if (ifc.sched_idle !== 1'b1) $display("FAIL mid_rst_idle got=%0b want=1", ifc.sched_idle); else passCnt++;
    ifc.done_valid = 1'b1;
    ifc.done_rd    = 5'd3;
    step(1);
    ifc.done_valid = 1'b0;
    totalCnt++; if (dut.sb !== 32'h0) $display("FAIL mid_stale_done_sb got=%h want=0", dut.sb); else passCnt++;
    totalCnt++; if (ifc.sched_idle !== 1'b1) $display("FAIL mid_stale_done_idle got=%0b want=1", ifc.sched_idle); else passCnt++;
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    RST      = 1'b1;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    ifc.disp_ready = 1'b0;
    ifc.done_valid = 1'b0;
    ifc.done_rd    = 5'd0;
    step(2);
    test_reset();
    test_basic_dispatch();
    test_raw_hazard();
    test_queue_full();
    test_waw_hazard();
    test_output_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
